// File: rtl/eclk_access_ctrl_pkg.sv
// eclk_access_ctrl_pkg: shared FSM encodings and E-clock tick constants for the CIA access sequencer
package eclk_access_ctrl_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_VMA, ST_EHI, ST_ACK} state_t;
  localparam int E_VMA = 2;
  localparam int E_EHI = 6;
  localparam int E_LAST = 9;
  localparam int E_PERIOD = 10;
endpackage

// File: rtl/eclk_rr_arb2.sv
// eclk_rr_arb2: two-way round-robin arbiter, one-hot grant while en, requester 0 wins the first tie
module eclk_rr_arb2 (
  input  logic       clk_28,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;
  assign gnt = !en ? 2'b00 : &req ? (last_grant ? 2'b01 : 2'b10) : req;
  // remember who was served last so a tie goes to the other side
  always_ff @(posedge clk_28) begin
    if (rst) last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
  end
endmodule

// File: rtl/eclk_access_ctrl.sv
// eclk_access_ctrl: shares the E-clock CIA access slot between the CPU bridge and the host controller
module eclk_access_ctrl
  import eclk_access_ctrl_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int VMA_TICK = E_VMA,
  parameter int EHI_TICK = E_EHI,
  parameter int ELAST_TICK = E_LAST
) (
  input  logic                clk_28,
  input  logic                rst,
  input  logic                clk7_en,
  input  logic [E_PERIOD-1:0] eclk,
  input  logic                req0,
  input  logic                req1,
  input  logic                sel0,
  input  logic                sel1,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       addr0,
  input  logic [AW-1:0]       addr1,
  input  logic [DW-1:0]       wdata0,
  input  logic [DW-1:0]       wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [DW-1:0]       rdata0,
  output logic [DW-1:0]       rdata1,
  output logic                e_vma,
  output logic                ciaa_cs,
  output logic                ciab_cs,
  output logic                e_we,
  output logic [AW-1:0]       e_addr,
  output logic [DW-1:0]       e_wdata,
  input  logic [DW-1:0]       e_rdata
);
  localparam logic [E_PERIOD-1:0] M_VMA = E_PERIOD'(1) << VMA_TICK;
  localparam logic [E_PERIOD-1:0] M_EHI = E_PERIOD'(1) << EHI_TICK;
  localparam logic [E_PERIOD-1:0] M_LAST = E_PERIOD'(1) << ELAST_TICK;
  state_t state, state_nx;
  logic [1:0] gnt;
  logic gid, e_sel, tick_vma, tick_ehi, tick_last;
  assign tick_vma = clk7_en && eclk == M_VMA;
  assign tick_ehi = clk7_en && eclk == M_EHI;
  assign tick_last = clk7_en && eclk == M_LAST;
  assign ack0 = state == ST_ACK && !gid;
  assign ack1 = state == ST_ACK && gid;
  eclk_rr_arb2 u_arb (
    .clk_28(clk_28),
    .rst(rst),
    .en(state == ST_IDLE),
    .req({req1, req0}),
    .gnt(gnt)
  );
  // state register
  always_ff @(posedge clk_28) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  // each phase advances only on its E-tick, so an unlocked clock parks the FSM in SYNC
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = |gnt ? ST_SYNC : ST_IDLE;
      ST_SYNC: state_nx = tick_vma ? ST_VMA : ST_SYNC;
      ST_VMA:  state_nx = tick_ehi ? ST_EHI : ST_VMA;
      ST_EHI:  state_nx = tick_last ? ST_ACK : ST_EHI;
      default: state_nx = ST_IDLE;
    endcase
  end
  // latch the winner at grant, drive the CIA bus between VMA and LAST ticks, capture read data at LAST
  always_ff @(posedge clk_28) begin
    if (rst) begin
      {gid, e_sel, e_we, e_vma, ciaa_cs, ciab_cs} <= '0;
      e_addr <= '0;
      e_wdata <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (|gnt) begin
        gid <= gnt[1];
        e_sel <= gnt[1] ? sel1 : sel0;
        e_we <= gnt[1] ? we1 : we0;
        e_addr <= gnt[1] ? addr1 : addr0;
        e_wdata <= gnt[1] ? wdata1 : wdata0;
      end
      if (state == ST_SYNC && tick_vma) begin
        e_vma <= 1'b1;
        ciaa_cs <= !e_sel;
        ciab_cs <= e_sel;
      end
      if (state == ST_EHI && tick_last) begin
        {e_vma, ciaa_cs, ciab_cs} <= '0;
        if (!e_we && !gid) rdata0 <= e_rdata;
        if (!e_we && gid) rdata1 <= e_rdata;
      end
    end
  end
endmodule

// File: tb/tb_eclk_access_ctrl.sv
// tb_eclk_access_ctrl: directed checks of E-clock alignment, arbitration, reset and unlocked-clock behaviour
module tb_eclk_access_ctrl;
  logic clk_28 = 0, rst = 1, clk7_en = 0;
  logic [9:0] eclk = '0;
  logic req0 = 0, req1 = 0, sel0 = 0, sel1 = 0, we0 = 0, we1 = 0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0, e_rdata = '0;
  logic ack0, ack1, e_vma, ciaa_cs, ciab_cs, e_we;
  logic [7:0] rdata0, rdata1, e_wdata;
  logic [3:0] e_addr;
  logic locked = 1;
  int tests = 0, fails = 0;
  int n_ack0 = 0, n_ack1 = 0, n_csb = 0, n_bad = 0;

  eclk_access_ctrl dut (
    .clk_28(clk_28), .rst(rst), .clk7_en(clk7_en), .eclk(eclk),
    .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .e_vma(e_vma), .ciaa_cs(ciaa_cs), .ciab_cs(ciab_cs), .e_we(e_we),
    .e_addr(e_addr), .e_wdata(e_wdata), .e_rdata(e_rdata)
  );

  always #5 clk_28 = ~clk_28;

  initial begin
    int ph, et;
    ph = 0;
    et = 0;
    forever begin
      @(negedge clk_28);
      ph = (ph + 1) % 4;
      if (ph == 0) et = (et + 1) % 10;
      clk7_en = (ph == 3);
      eclk = locked ? (10'd1 << et) : 10'd0;
    end
  end

  initial begin
    forever begin
      @(negedge clk_28);
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (ciab_cs) n_csb++;
      if ((ciaa_cs && ciab_cs) || (e_vma != (ciaa_cs | ciab_cs))) n_bad++;
    end
  end

  task automatic sync_tick(input int k);
    bit hit;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk_28);
      hit = clk7_en && eclk[k];
    end
    #1;
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL tick%0d_timeout: observed no tick, required tick within 100 cycles", k);
    end
  endtask

  task automatic wait_ack(output logic [1:0] got);
    got = 2'b00;
    for (int i = 0; i < 200 && got == 2'b00; i++) begin
      @(posedge clk_28);
      #1;
      got = {ack1, ack0};
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_28);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    cycles(3);
    tests++;
    if ({ack0, ack1, e_vma, ciaa_cs, ciab_cs, e_we, e_addr, e_wdata, rdata0, rdata1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: observed %b %b %b %b %b %b %h %h %h %h required all zero",
               ack0, ack1, e_vma, ciaa_cs, ciab_cs, e_we, e_addr, e_wdata, rdata0, rdata1);
    end
    rst = 0;
  endtask

  task automatic test_single_read;
    int a0, cb;
    sync_tick(9);
    a0 = n_ack0;
    cb = n_csb;
    req0 = 1; sel0 = 0; we0 = 0; addr0 = 4'hD; e_rdata = 8'h5A;
    sync_tick(1);
    tests++;
    if (e_vma !== 1'b0) begin fails++; $display("FAIL read_vma_early: observed %b required 0", e_vma); end
    sync_tick(2);
    tests++;
    if ({e_vma, ciaa_cs, ciab_cs, e_we, e_addr} !== {3'b110, 1'b0, 4'hD}) begin
      fails++;
      $display("FAIL read_bus: observed vma=%b a=%b b=%b we=%b addr=%h required 1 1 0 0 d", e_vma, ciaa_cs, ciab_cs, e_we, e_addr);
    end
    sync_tick(8);
    tests++;
    if ({e_vma, ciaa_cs} !== 2'b11) begin fails++; $display("FAIL read_vma_tick8: observed %b%b required 11", e_vma, ciaa_cs); end
    sync_tick(9);
    req0 = 0;
    tests++;
    if ({ack0, ack1, e_vma, ciaa_cs, rdata0} !== {4'b1000, 8'h5A}) begin
      fails++;
      $display("FAIL read_ack: observed ack0=%b ack1=%b vma=%b a=%b rdata0=%h required 1 0 0 0 5a", ack0, ack1, e_vma, ciaa_cs, rdata0);
    end
    cycles(20);
    tests++;
    if (n_ack0 - a0 != 1 || n_csb != cb || rdata0 !== 8'h5A) begin
      fails++;
      $display("FAIL read_once: observed acks=%0d csb_cycles=%0d rdata0=%h required 1 0 5a", n_ack0 - a0, n_csb - cb, rdata0);
    end
  endtask

  task automatic test_late_grant;
    int a1;
    sync_tick(4);
    a1 = n_ack1;
    req1 = 1; sel1 = 1; we1 = 1; addr1 = 4'h7; wdata1 = 8'hC3; e_rdata = 8'hFF;
    sync_tick(9);
    tests++;
    if (e_vma !== 1'b0 || n_csb != 0) begin
      fails++;
      $display("FAIL late_no_vma: observed vma=%b csb_cycles=%0d required 0 0", e_vma, n_csb);
    end
    sync_tick(2);
    tests++;
    if ({e_vma, ciaa_cs, ciab_cs, e_we, e_wdata, e_addr} !== {4'b1011, 8'hC3, 4'h7}) begin
      fails++;
      $display("FAIL late_bus: observed vma=%b a=%b b=%b we=%b wdata=%h addr=%h required 1 0 1 1 c3 7",
               e_vma, ciaa_cs, ciab_cs, e_we, e_wdata, e_addr);
    end
    sync_tick(9);
    req1 = 0;
    tests++;
    if ({ack1, ack0, e_vma, ciab_cs, rdata1} !== {4'b1000, 8'h00}) begin
      fails++;
      $display("FAIL late_ack: observed ack1=%b ack0=%b vma=%b b=%b rdata1=%h required 1 0 0 0 00", ack1, ack0, e_vma, ciab_cs, rdata1);
    end
    cycles(20);
    tests++;
    if (n_ack1 - a1 != 1) begin fails++; $display("FAIL late_once: observed %0d acks required 1", n_ack1 - a1); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] got;
    logic [7:0] rd;
    test_reset();
    sync_tick(9);
    req0 = 1; sel0 = 0; we0 = 0; addr0 = 4'h1;
    req1 = 1; sel1 = 1; we1 = 0; addr1 = 4'h2;
    for (int i = 0; i < 4; i++) begin
      e_rdata = 8'h20 + 8'(i);
      wait_ack(got);
      if (i == 3) begin req0 = 0; req1 = 0; end
      rd = got[1] ? rdata1 : rdata0;
      tests++;
      if (got !== ((i % 2) ? 2'b10 : 2'b01) || rd !== 8'h20 + 8'(i)) begin
        fails++;
        $display("FAIL alternate_%0d: observed ack=%b rdata=%h required ack=%b rdata=%h", i, got, rd, (i % 2) ? 2'b10 : 2'b01, 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_req_drop;
    int a0;
    logic [1:0] got;
    cycles(5);
    sync_tick(9);
    a0 = n_ack0;
    req0 = 1; sel0 = 0; we0 = 0; addr0 = 4'h3; e_rdata = 8'h77;
    sync_tick(7);
    req0 = 0;
    wait_ack(got);
    tests++;
    if (got !== 2'b01 || rdata0 !== 8'h77) begin
      fails++;
      $display("FAIL drop_ack: observed ack=%b rdata0=%h required 01 77", got, rdata0);
    end
    cycles(60);
    tests++;
    if (n_ack0 - a0 != 1 || e_vma !== 1'b0) begin
      fails++;
      $display("FAIL drop_once: observed acks=%0d vma=%b required 1 0", n_ack0 - a0, e_vma);
    end
  endtask

  task automatic test_reset_mid;
    int a0, a1;
    logic [1:0] got;
    sync_tick(9);
    a0 = n_ack0;
    a1 = n_ack1;
    req0 = 1; sel0 = 1; we0 = 0; addr0 = 4'h9;
    sync_tick(3);
    tests++;
    if ({e_vma, ciab_cs} !== 2'b11) begin fails++; $display("FAIL mid_pre: observed %b%b required 11", e_vma, ciab_cs); end
    rst = 1;
    cycles(1);
    rst = 0;
    req0 = 0;
    tests++;
    if ({e_vma, ciaa_cs, ciab_cs, ack0, ack1} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset: observed vma=%b a=%b b=%b ack0=%b ack1=%b required 0", e_vma, ciaa_cs, ciab_cs, ack0, ack1);
    end
    cycles(60);
    tests++;
    if (n_ack0 != a0 || n_ack1 != a1) begin
      fails++;
      $display("FAIL mid_no_ack: observed %0d %0d extra acks required 0 0", n_ack0 - a0, n_ack1 - a1);
    end
    req0 = 1; req1 = 1; sel0 = 0; sel1 = 1;
    wait_ack(got);
    req0 = 0; req1 = 0;
    tests++;
    if (got !== 2'b01) begin fails++; $display("FAIL mid_tie: observed ack=%b required 01", got); end
  endtask

  task automatic test_unlocked;
    int a0;
    logic [1:0] got;
    cycles(5);
    sync_tick(9);
    a0 = n_ack0;
    locked = 0;
    req0 = 1; sel0 = 0; we0 = 0; addr0 = 4'h5; e_rdata = 8'h3C;
    cycles(80);
    tests++;
    if (e_vma !== 1'b0 || n_ack0 != a0) begin
      fails++;
      $display("FAIL unlocked_stall: observed vma=%b acks=%0d required 0 0", e_vma, n_ack0 - a0);
    end
    locked = 1;
    wait_ack(got);
    req0 = 0;
    tests++;
    if (got !== 2'b01 || rdata0 !== 8'h3C) begin
      fails++;
      $display("FAIL unlocked_resume: observed ack=%b rdata0=%h required 01 3c", got, rdata0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_late_grant();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    test_unlocked();
    cycles(5);
    tests++;
    if (n_bad != 0) begin fails++; $display("FAIL cs_vma_exclusive: observed %0d bad cycles required 0", n_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
